regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Shares the register-file write port between the WRITE_BACK stage and the debug unit's
//  register-write requests. WB has priority and never waits. Debug requests wait for a free
//  port; a starved debug request forces a one-cycle pipeline stall and takes the port then.
//  Sits between WRITE_BACK outputs / debug unit and the register file write port.
// PARAMETERS
//  NB_DATA      32  register data width
//  NB_REG       5   register address width
//  STARVE_LIMIT 4   blocked debug cycles tolerated before forcing a stall (>=1)
//  NB_STAT      16  width of the stall-event statistics counter
// PORTS
//  i_clock             in   1        system clock, rising edge
//  i_reset             in   1        synchronous, active-high reset
//  i_wb_reg_write      in   1        WB write request (o_WB_reg_write of WRITE_BACK)
//  i_wb_selected_reg   in   NB_REG   WB destination register
//  i_wb_selected_data  in   NB_DATA  WB write data
//  i_dbg_valid         in   1        debug write request valid; held until accepted
//  i_dbg_reg           in   NB_REG   debug destination register
//  i_dbg_data          in   NB_DATA  debug write data
//  o_dbg_ready         out  1        debug request accepted this cycle (combinational)
//  o_pipe_stall        out  1        freeze IF..MEM/WB latches this cycle (registered state)
//  o_rf_write          out  1        register-file write enable (registered)
//  o_rf_addr           out  NB_REG   register-file write address (registered)
//  o_rf_data           out  NB_DATA  register-file write data (registered)
//  o_stall_events      out  NB_STAT  saturating count of forced stalls
// BEHAVIOUR
//  - Reset: state IDLE, wait count 0, o_rf_write/o_rf_addr/o_rf_data/o_stall_events = 0,
//    o_pipe_stall = 0. Reset mid-wait drops the pending request (never acknowledged).
//  - wb_eff = i_wb_reg_write && (i_wb_selected_reg != 0); WB writes to r0 never use the port.
//  - States: IDLE (no blocked request), WAIT (debug blocked >=1 cycle), STALL (forced slot).
//  - IDLE/WAIT: o_dbg_ready = i_dbg_valid && !wb_eff. STALL: o_dbg_ready = i_dbg_valid.
//  - Port select: STALL -> debug; else wb_eff -> WB; else accepted debug; else no write.
//  - Debug write to r0: accepted (ready=1), o_rf_write stays 0.
//  - Write latency: selected request drives o_rf_* on the next rising edge (1 cycle).
//  - Wait counter: +1 each cycle i_dbg_valid && !o_dbg_ready; cleared on accept or
//    when valid drops. Width $clog2(STARVE_LIMIT+1); never wraps.
//  - IDLE->WAIT: debug blocked. WAIT->IDLE: accepted or valid dropped.
//    IDLE/WAIT->STALL: blocked and count == STARVE_LIMIT-1. STALL->IDLE always.
//  - o_pipe_stall = (state == STALL). Pipeline holds MEM/WB during stall, so the WB entry
//    present in the STALL cycle is ignored here and is re-presented next cycle (not lost).
//  - Valid dropped while in STALL: no write, back to IDLE, stall still counted.
//  - o_stall_events +1 on every entry to STALL, saturates at all-ones.
// STRUCTURE
//  - State encoding (IDLE/WAIT/STALL) as localparams in shared pipeline defines include,
//    alongside NB_DATA/NB_REG defaults used by WRITE_BACK.
//  - Single always block for state/counters, one for registered port outputs; no sub-module.
// TESTING
//  1 Reset: i_reset=1 two cycles with dbg/WB active -> all outputs 0, o_dbg_ready=0 during.
//  2 WB only: wb_write=1 reg=5 data=0xBB -> next cycle o_rf_write=1 addr=5 data=0xBB.
//  3 Free port: wb_write=0, dbg valid reg=3 data=0xAA -> ready=1 same cycle; next cycle
//    o_rf_write=1 addr=3 data=0xAA; no stall.
//  4 Starvation: STARVE_LIMIT=4, WB writes r7 every cycle, dbg valid reg=9 data=0x55 at
//    cycle 0 -> ready=0 cycles 0-3, cycle 4 o_pipe_stall=1 ready=1, cycle 5 o_rf addr=9
//    data=0x55, o_stall_events=1, WB r7 write resumes cycle 6.
//  5 r0 handling: WB write r0 with dbg valid -> dbg granted same cycle; dbg write r0 ->
//    ready=1, o_rf_write=0.
//  6 Abort: dbg blocked 2 cycles then valid dropped -> IDLE, counter 0, no stall ever;
//    reset asserted in WAIT -> IDLE, request not accepted.

Source files
------------

// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// arbiter state encoding and the wait-counter width helper.
package regfile_wport_arbiter_pkg;

    localparam int NB_DATA_DEFAULT      = 32;
    localparam int NB_REG_DEFAULT       = 5;
    localparam int STARVE_LIMIT_DEFAULT = 4;
    localparam int NB_STAT_DEFAULT      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_e;

    // The wait counter must be able to hold STARVE_LIMIT itself without wrapping.
    function automatic int waitCntWidth(input int starveLimit);
        return $clog2(starveLimit + 1);
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between WRITE_BACK (priority, never waits) and
// debug register writes; a starved debug request forces a one-cycle pipeline stall.
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEFAULT,
    parameter int NB_REG       = NB_REG_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int NB_STAT      = NB_STAT_DEFAULT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_wb_reg_write,
    input  logic [NB_REG-1:0]  i_wb_selected_reg,
    input  logic [NB_DATA-1:0] i_wb_selected_data,
    input  logic               i_dbg_valid,
    input  logic [NB_REG-1:0]  i_dbg_reg,
    input  logic [NB_DATA-1:0] i_dbg_data,
    output logic               o_dbg_ready,
    output logic               o_pipe_stall,
    output logic               o_rf_write,
    output logic [NB_REG-1:0]  o_rf_addr,
    output logic [NB_DATA-1:0] o_rf_data,
    output logic [NB_STAT-1:0] o_stall_events
);

    localparam int NB_CNT = waitCntWidth(STARVE_LIMIT);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(STARVE_LIMIT - 1);
    localparam logic [NB_CNT-1:0] CNT_MAX  = NB_CNT'(STARVE_LIMIT);

    arb_state_e         state_q, state_d;
    logic [NB_CNT-1:0]  waitCnt_q, waitCnt_d;
    logic [NB_STAT-1:0] stallEvents_q, stallEvents_d;
    logic               rfWrite_q, rfWrite_d;
    logic [NB_REG-1:0]  rfAddr_q, rfAddr_d;
    logic [NB_DATA-1:0] rfData_q, rfData_d;

    logic wbEff;
    logic dbgReady;
    logic dbgBlocked;

    always_comb begin
        wbEff      = i_wb_reg_write && (i_wb_selected_reg != '0);
        dbgReady   = 1'b0;
        if (!i_reset) begin
            dbgReady = (state_q == ST_STALL) ? i_dbg_valid : (i_dbg_valid && !wbEff);
        end
        dbgBlocked = i_dbg_valid && !dbgReady;
    end

    always_comb begin
        state_d       = state_q;
        waitCnt_d     = '0;
        stallEvents_d = stallEvents_q;

        if (dbgBlocked && (waitCnt_q != CNT_MAX)) begin
            waitCnt_d = waitCnt_q + NB_CNT'(1);
        end

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (dbgBlocked) begin
                    state_d = (waitCnt_q == CNT_LAST) ? ST_STALL : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if ((state_d == ST_STALL) && (state_q != ST_STALL) && (stallEvents_q != '1)) begin
            stallEvents_d = stallEvents_q + NB_STAT'(1);
        end
    end

    // In the stall slot the WB entry is frozen upstream and re-presented, so only debug may write.
    always_comb begin
        rfWrite_d = 1'b0;
        rfAddr_d  = rfAddr_q;
        rfData_d  = rfData_q;
        if (state_q == ST_STALL) begin
            if (i_dbg_valid && (i_dbg_reg != '0)) begin
                rfWrite_d = 1'b1;
                rfAddr_d  = i_dbg_reg;
                rfData_d  = i_dbg_data;
            end
        end else if (wbEff) begin
            rfWrite_d = 1'b1;
            rfAddr_d  = i_wb_selected_reg;
            rfData_d  = i_wb_selected_data;
        end else if (dbgReady && (i_dbg_reg != '0)) begin
            rfWrite_d = 1'b1;
            rfAddr_d  = i_dbg_reg;
            rfData_d  = i_dbg_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            waitCnt_q     <= '0;
            stallEvents_q <= '0;
        end else begin
            state_q       <= state_d;
            waitCnt_q     <= waitCnt_d;
            stallEvents_q <= stallEvents_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rfWrite_q <= 1'b0;
            rfAddr_q  <= '0;
            rfData_q  <= '0;
        end else begin
            rfWrite_q <= rfWrite_d;
            rfAddr_q  <= rfAddr_d;
            rfData_q  <= rfData_d;
        end
    end

    assign o_dbg_ready    = dbgReady;
    assign o_pipe_stall   = (state_q == ST_STALL);
    assign o_rf_write     = rfWrite_q;
    assign o_rf_addr      = rfAddr_q;
    assign o_rf_data      = rfData_q;
    assign o_stall_events = stallEvents_q;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_regfile_wport_arbiter;

    localparam int NB_DATA      = 32;
    localparam int NB_REG       = 5;
    localparam int STARVE_LIMIT = 4;
    localparam int NB_STAT      = 16;
    localparam int STAT_MAX     = (1 << NB_STAT) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               wbWrite = 1'b0;
    logic [NB_REG-1:0]  wbReg = '0;
    logic [NB_DATA-1:0] wbData = '0;
    logic               dbgValid = 1'b0;
    logic [NB_REG-1:0]  dbgReg = '0;
    logic [NB_DATA-1:0] dbgData = '0;
    logic               dbgReady;
    logic               pipeStall;
    logic               rfWrite;
    logic [NB_REG-1:0]  rfAddr;
    logic [NB_DATA-1:0] rfData;
    logic [NB_STAT-1:0] stallEvents;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: how long the debug request has been refused, whether this
    // cycle is the forced stall slot, and what the write port should show next.
    int          mBlocked = 0;
    bit          mStall   = 1'b0;
    int          mEvents  = 0;
    bit          mWrite   = 1'b0;
    int unsigned mAddr    = 0;
    int unsigned mData    = 0;
    bit          lastReady;

    regfile_wport_arbiter #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .STARVE_LIMIT(STARVE_LIMIT), .NB_STAT(NB_STAT)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .i_wb_reg_write(wbWrite),
        .i_wb_selected_reg(wbReg),
        .i_wb_selected_data(wbData),
        .i_dbg_valid(dbgValid),
        .i_dbg_reg(dbgReg),
        .i_dbg_data(dbgData),
        .o_dbg_ready(dbgReady),
        .o_pipe_stall(pipeStall),
        .o_rf_write(rfWrite),
        .o_rf_addr(rfAddr),
        .o_rf_data(rfData),
        .o_stall_events(stallEvents)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check the combinational ready and stall flag,
    // advance the model, then check the registered port outputs after the edge.
    task automatic applyStimulus(input logic rst, input logic wbw, input logic [NB_REG-1:0] wbr,
                                 input logic [NB_DATA-1:0] wbd, input logic dv,
                                 input logic [NB_REG-1:0] dr, input logic [NB_DATA-1:0] dd);
        bit wbUsesPort;
        bit expReady;
        bit refused;
        bit goStall;
        @(negedge clock);
        reset = rst; wbWrite = wbw; wbReg = wbr; wbData = wbd;
        dbgValid = dv; dbgReg = dr; dbgData = dd;
        #1;
        wbUsesPort = wbw && (wbr != 0);
        if (rst)         expReady = 1'b0;
        else if (mStall) expReady = dv;
        else             expReady = dv && !wbUsesPort;
        checkOutput("dbg_ready", {63'd0, dbgReady}, {63'd0, expReady});
        checkOutput("pipe_stall", {63'd0, pipeStall}, {63'd0, mStall});

        if (rst) begin
            mBlocked = 0; mStall = 1'b0; mEvents = 0;
            mWrite = 1'b0; mAddr = 0; mData = 0;
        end else begin
            refused = dv && !expReady;
            mWrite  = 1'b0;
            if (mStall) begin
                if (dv && dr != 0) begin mWrite = 1'b1; mAddr = dr; mData = dd; end
            end else if (wbUsesPort) begin
                mWrite = 1'b1; mAddr = wbr; mData = wbd;
            end else if (expReady && dr != 0) begin
                mWrite = 1'b1; mAddr = dr; mData = dd;
            end
            goStall  = refused && (mBlocked + 1 >= STARVE_LIMIT);
            mBlocked = refused ? mBlocked + 1 : 0;
            if (goStall && mEvents < STAT_MAX) mEvents++;
            mStall = goStall;
        end
        lastReady = expReady;

        @(posedge clock);
        #1;
        checkOutput("rf_write", {63'd0, rfWrite}, {63'd0, mWrite});
        if (mWrite) begin
            checkOutput("rf_addr", 64'(rfAddr), 64'(mAddr));
            checkOutput("rf_data", 64'(rfData), 64'(mData));
        end
        checkOutput("stall_events", 64'(stallEvents), 64'(mEvents));
    endtask

    initial begin
        bit                 pending;
        logic [NB_REG-1:0]  pReg;
        logic [NB_DATA-1:0] pData;

        // Bring the DUT out of its unknown power-up state before any checking.
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Reset held with both requesters active: nothing accepted, all outputs cleared.
        applyStimulus(1, 1, 5'd5, 32'h11, 1, 5'd3, 32'h22);
        applyStimulus(1, 1, 5'd5, 32'h11, 1, 5'd3, 32'h22);
        checkOutput("reset_rf_write", {63'd0, rfWrite}, 64'd0);
        checkOutput("reset_rf_addr", 64'(rfAddr), 64'd0);
        checkOutput("reset_rf_data", 64'(rfData), 64'd0);

        // WB only.
        applyStimulus(0, 1, 5'd5, 32'hBB, 0, 5'd0, 32'h0);
        checkOutput("wb_only_addr", 64'(rfAddr), 64'd5);
        checkOutput("wb_only_data", 64'(rfData), 64'hBB);

        // Free port: debug accepted immediately.
        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd3, 32'hAA);
        checkOutput("free_ready", {63'd0, lastReady}, 64'd1);
        checkOutput("free_addr", 64'(rfAddr), 64'd3);
        checkOutput("free_data", 64'(rfData), 64'hAA);

        // Starvation: WB hogs r7, debug forced in on the fifth cycle.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 1, 5'd7, 32'h700 + c, 1, 5'd9, 32'h55);
            checkOutput("starve_refused", {63'd0, lastReady}, 64'd0);
        end
        checkOutput("starve_stall_now", {63'd0, pipeStall}, 64'd1);
        applyStimulus(0, 1, 5'd7, 32'h704, 1, 5'd9, 32'h55);
        checkOutput("starve_granted", {63'd0, lastReady}, 64'd1);
        checkOutput("starve_addr", 64'(rfAddr), 64'd9);
        checkOutput("starve_data", 64'(rfData), 64'h55);
        checkOutput("starve_events", 64'(stallEvents), 64'd1);
        applyStimulus(0, 1, 5'd7, 32'h704, 0, 5'd0, 32'h0);
        checkOutput("starve_wb_resume", 64'(rfAddr), 64'd7);

        // r0 handling for both requesters.
        applyStimulus(0, 1, 5'd0, 32'hDEAD, 1, 5'd4, 32'h44);
        checkOutput("wb_r0_dbg_addr", 64'(rfAddr), 64'd4);
        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h99);
        checkOutput("dbg_r0_ready", {63'd0, lastReady}, 64'd1);
        checkOutput("dbg_r0_nowrite", {63'd0, rfWrite}, 64'd0);

        // Abort: blocked twice, then dropped; no stall must follow.
        applyStimulus(0, 1, 5'd6, 32'h60, 1, 5'd2, 32'h20);
        applyStimulus(0, 1, 5'd6, 32'h61, 1, 5'd2, 32'h20);
        applyStimulus(0, 1, 5'd6, 32'h62, 0, 5'd0, 32'h0);
        applyStimulus(0, 1, 5'd6, 32'h63, 0, 5'd0, 32'h0);
        checkOutput("abort_no_stall", {63'd0, pipeStall}, 64'd0);

        // Reset while waiting drops the request.
        applyStimulus(0, 1, 5'd6, 32'h64, 1, 5'd2, 32'h21);
        applyStimulus(0, 1, 5'd6, 32'h65, 1, 5'd2, 32'h21);
        applyStimulus(1, 1, 5'd6, 32'h66, 1, 5'd2, 32'h21);
        applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkOutput("reset_wait_nowrite", {63'd0, rfWrite}, 64'd0);

        // Valid dropped inside the stall slot: slot counted, nothing written.
        for (int c = 0; c < 4; c++) applyStimulus(0, 1, 5'd8, 32'h80 + c, 1, 5'd1, 32'h10);
        applyStimulus(0, 1, 5'd8, 32'h84, 0, 5'd0, 32'h0);
        checkOutput("stall_drop_nowrite", {63'd0, rfWrite}, 64'd0);
        checkOutput("stall_drop_events", 64'(stallEvents), 64'd1);

        // Randomized traffic with a held debug request, occasional aborts and resets.
        pending = 1'b0; pReg = '0; pData = '0;
        for (int i = 0; i < 400; i++) begin
            logic rst;
            logic wbw;
            rst = ($urandom_range(0, 99) == 0);
            wbw = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 2) == 0) begin
                pending = 1'b1;
                pReg    = NB_REG'($urandom_range(0, 31));
                pData   = $urandom;
            end else if (pending && $urandom_range(0, 15) == 0) begin
                pending = 1'b0;
            end
            applyStimulus(rst, wbw, NB_REG'($urandom_range(0, 31)), $urandom, pending, pReg, pData);
            if (lastReady || rst) pending = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
